// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_MIN_INT = 32'h8000_0000;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic        [WIDTH:0] rem_sh;
  logic signed [WIDTH:0] trial;

  // rem < divisor <= 2^(WIDTH-1), so one extra bit keeps the trial sign exact
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = $signed(rem_sh) - $signed({1'b0, divisor});
    if (trial[WIDTH]) begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (restoring, one quotient bit per cycle).
// Define DIV_REMAINDER_EN to expose the signed remainder on data_remainder.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  div_state_t             state;
  logic [DIV_CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]       rem_p0;
  logic [WIDTH-1:0]       quo_p0;
  logic [WIDTH-1:0]       divisor_p0;
  logic                   q_neg;
`ifdef DIV_REMAINDER_EN
  logic                   r_neg;
`endif

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             div_zero;
  logic             div_ovf;

  assign div_zero = (data_operandB == '0);
  assign div_ovf  = (data_operandA == MIN_INT) && (data_operandB == '1);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_p0),
    .quo     (quo_p0),
    .divisor (divisor_p0),
    .rem_next(rem_nx),
    .quo_next(quo_nx)
  );

  // A start pulse takes priority over whatever the FSM is doing, which is
  // what makes a mid-operation ctrl_div abort without producing a RDY.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem_p0         <= '0;
      quo_p0         <= '0;
      divisor_p0     <= '0;
      q_neg          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      r_neg          <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_div) begin
        if (div_zero || div_ovf) begin
          data_result    <= div_zero ? '0 : MIN_INT;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
          data_remainder <= '0;
`endif
          state          <= DONE;
        end else begin
          quo_p0     <= mag(data_operandA);
          divisor_p0 <= mag(data_operandB);
          rem_p0     <= '0;
          cnt        <= '0;
          q_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef DIV_REMAINDER_EN
          r_neg      <= data_operandA[WIDTH-1];
`endif
          state      <= RUN;
        end
      end else begin
        case (state)
          IDLE: state <= IDLE;
          // ---- iterate: one quotient bit per cycle ----
          RUN: begin
            rem_p0 <= rem_nx;
            quo_p0 <= quo_nx;
            cnt    <= cnt + DIV_CNT_W'(1);
            if (cnt == DIV_CNT_W'(ITERS - 1)) state <= FIX;
          end
          // ---- sign fix-up and result register ----
          FIX: begin
            data_result    <= cond_neg(quo_p0, q_neg);
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
`ifdef DIV_REMAINDER_EN
            data_remainder <= cond_neg(rem_p0, r_neg);
`endif
            state          <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed divides against a signed-arithmetic model.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  div_unit dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_div      (ctrl_div),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder(data_remainder)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain signed division, truncating toward zero.
  function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa, sb_;
    sa = a;
    sb_ = b;
    e.cyc = 0;
    if (b == 32'd0) begin
      e.res = 32'd0; e.exc = 1'b1; e.rem = 32'd0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.exc = 1'b1; e.rem = 32'd0;
    end else begin
      e.res = sa / sb_; e.exc = 1'b0; e.rem = sa % sb_;
    end
    return e;
  endfunction

  // Called at a negedge; the start is sampled at the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    e = ref_div(a, b);
    e.cyc = cyc + 1 + (e.exc ? 0 : 33);
    sb.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every RDY must match the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rdy_cycle", cyc, e.cyc);
        chk("result", data_result, e.res);
        chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_EN
        chk("remainder", data_remainder, e.rem);
`endif
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rdy actual=0 required=1 (cycle %0d expected %0d)", cyc, e.cyc);
    end
  end

  logic [31:0] ra, rb;
  int mode, gap;

  initial begin
    reset = 1'b1;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("reset_remainder", data_remainder, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clock);

    // Directed cases
    issue(32'd100, 32'd7);                 wait_idle(60);
    issue(-32'sd100, 32'd7);               wait_idle(60);
    issue(32'd100, -32'sd7);               wait_idle(60);
    issue(32'd7, -32'sd2);                 wait_idle(60);
    issue(-32'sd7, 32'd2);                 wait_idle(60);
    issue(32'd5, 32'd0);                   wait_idle(60);
    issue(32'h8000_0000, 32'hFFFF_FFFF);   wait_idle(60);
    issue(32'h8000_0000, 32'd1);           wait_idle(60);
    issue(32'h8000_0000, 32'h8000_0000);   wait_idle(60);
    issue(32'd0, -32'sd9);                 wait_idle(60);
    issue(32'h7FFF_FFFF, 32'h8000_0000);   wait_idle(60);

    // Abort: second start 10 cycles after the first
    issue(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    issue(32'd9, 32'd4);
    wait_idle(60);

    // Back-to-back: new start during the DONE cycle
    issue(32'd12345, -32'sd17);
    repeat (33) @(negedge clock);
    issue(-32'sd999, 32'd10);
    wait_idle(60);

    // Consecutive exceptional starts
    issue(32'd1, 32'd0);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(10);

    // Random traffic, gaps may abort in-flight divides
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 5);
      ra = $urandom;
      rb = $urandom;
      case (mode)
        1: begin ra = $urandom_range(0, 2000) - 1000; rb = $urandom_range(0, 2000) - 1000; end
        2: rb = 32'd0;
        3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd1; end
        4: rb = $urandom_range(0, 40) - 20;
        default: ;
      endcase
      issue(ra, rb);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 40;
      repeat (gap) @(negedge clock);
    end
    wait_idle(60);

    // Reset mid-RUN, with a simultaneous start that must be ignored
    issue(32'd55555, 32'd3);
    repeat (18) @(negedge clock);
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    reset = 1'b1;
    ctrl_div = 1'b1;
    data_operandA = 32'd8;
    data_operandB = 32'd2;
    @(negedge clock);
    reset = 1'b0;
    ctrl_div = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("post_reset_result", data_result, 32'd0);
      chk("post_reset_exception", {31'd0, data_exception}, 32'd0);
`ifdef DIV_REMAINDER_EN
      chk("post_reset_remainder", data_remainder, 32'd0);
`endif
      @(negedge clock);
    end

    // Still functional after reset
    issue(32'd100, 32'd7);
    wait_idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
